// File: rtl/rd0_addr_ctrl_if.sv
// Request bus between the display-side read address controller and the DDR read engine.
// The master side is the address controller; the slave side is the read engine plus frame sources.
interface rd0_addr_ctrl_if #(
    parameter int ADDR_WIDTH   = 30,
    parameter int RD_NUM_WIDTH = 28
);
    logic                    rd_vs;
    logic                    rd_ddr_done;
    logic [4:0]              wr_fram_cnt;
    logic                    rd_addr_valid;
    logic [ADDR_WIDTH-1:0]   rd_ddr_addr;
    logic [RD_NUM_WIDTH-1:0] rd_ddr_num;
    logic [4:0]              rd_fram_cnt;
    logic                    rd_repeat;
    logic                    rd_err;

    modport master (
        input  rd_vs, rd_ddr_done, wr_fram_cnt,
        output rd_addr_valid, rd_ddr_addr, rd_ddr_num, rd_fram_cnt, rd_repeat, rd_err
    );

    modport slave (
        output rd_vs, rd_ddr_done, wr_fram_cnt,
        input  rd_addr_valid, rd_ddr_addr, rd_ddr_num, rd_fram_cnt, rd_repeat, rd_err
    );
endinterface

// File: rtl/rd0_addr_ctrl.sv
// Read-side DDR address controller: on each display vsync, requests one burst for the
// most recently completed frame slot in the ring buffer and waits for the read engine.
module rd0_addr_ctrl #(
    parameter logic [31:0] START_ADDR   = 32'h0000_0000,
    parameter logic [31:0] BLOCK_SIZE   = 32'h0008_0000,
    parameter logic [31:0] RD_NUM       = 32'd3600,
    parameter int          ADDR_WIDTH   = 30,
    parameter int          RD_NUM_WIDTH = 28,
    parameter logic [31:0] TIMEOUT      = 32'd4_000_000
) (
    input  logic            clk,
    input  logic            rst,
    rd0_addr_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, SETUP, REQ} state_t;

    state_t                  state_reg, state_next;
    logic [4:0]              wr_cnt_reg;
    logic                    wr_started_reg;
    logic                    vs_pending_reg, vs_pending_next;
    logic [4:0]              tgt_reg, tgt_next;
    logic [3:0]              dly_cnt_reg, dly_cnt_next;
    logic [31:0]             tmo_cnt_reg, tmo_cnt_next;
    logic [4:0]              rd_fram_cnt_reg, rd_fram_cnt_next;
    logic                    rd_ok_reg, rd_ok_next;
    logic                    rd_repeat_reg, rd_repeat_next;
    logic                    rd_err_reg, rd_err_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [RD_NUM_WIDTH-1:0] num_reg, num_next;

    logic [1:0] async_in;
    logic [1:0] rise;
    logic       vs_rise, done_rise;
    logic [4:0] tgt;

    assign async_in  = {bus.rd_ddr_done, bus.rd_vs};
    assign vs_rise   = rise[0];
    assign done_rise = rise[1];

    // Three-stage synchronizer per asynchronous level input; edge taken between stages 1 and 2.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] ff_reg;
            always_ff @(posedge clk) begin
                if (rst) ff_reg <= '0;
                else     ff_reg <= {ff_reg[1:0], async_in[gi]};
            end
            assign rise[gi] = ff_reg[1] & ~ff_reg[2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_reg     <= '0;
            wr_started_reg <= 1'b0;
        end else begin
            wr_cnt_reg <= bus.wr_fram_cnt;
            if (wr_cnt_reg != 5'd0) wr_started_reg <= 1'b1;
        end
    end

    // Newest completed slot; 5-bit wrap makes counter 0 point at slot 31.
    assign tgt = wr_cnt_reg - 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            vs_pending_reg  <= 1'b0;
            tgt_reg         <= '0;
            dly_cnt_reg     <= '0;
            tmo_cnt_reg     <= '0;
            rd_fram_cnt_reg <= '0;
            rd_ok_reg       <= 1'b0;
            rd_repeat_reg   <= 1'b0;
            rd_err_reg      <= 1'b0;
            addr_reg        <= '0;
            num_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            vs_pending_reg  <= vs_pending_next;
            tgt_reg         <= tgt_next;
            dly_cnt_reg     <= dly_cnt_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            rd_fram_cnt_reg <= rd_fram_cnt_next;
            rd_ok_reg       <= rd_ok_next;
            rd_repeat_reg   <= rd_repeat_next;
            rd_err_reg      <= rd_err_next;
            addr_reg        <= addr_next;
            num_reg         <= num_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        vs_pending_next  = vs_pending_reg;
        tgt_next         = tgt_reg;
        dly_cnt_next     = dly_cnt_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        rd_fram_cnt_next = rd_fram_cnt_reg;
        rd_ok_next       = rd_ok_reg;
        rd_repeat_next   = 1'b0;
        rd_err_next      = 1'b0;
        addr_next        = addr_reg;
        num_next         = num_reg;

        case (state_reg)
            IDLE: begin
                // A vsync before the writer has produced anything is simply dropped.
                if ((vs_rise || vs_pending_reg) && wr_started_reg) begin
                    state_next      = SETUP;
                    tgt_next        = tgt;
                    vs_pending_next = 1'b0;
                    dly_cnt_next    = '0;
                    addr_next       = ADDR_WIDTH'((START_ADDR + 32'(tgt) * BLOCK_SIZE) << 2);
                    num_next        = RD_NUM_WIDTH'(RD_NUM);
                    rd_repeat_next  = rd_ok_reg && (tgt == rd_fram_cnt_reg);
                end
            end
            SETUP: begin
                if (vs_rise) vs_pending_next = 1'b1;
                if (dly_cnt_reg > 4'd7) begin
                    state_next   = REQ;
                    tmo_cnt_next = '0;
                end else begin
                    dly_cnt_next = dly_cnt_reg + 4'd1;
                end
            end
            REQ: begin
                if (vs_rise) vs_pending_next = 1'b1;
                // Completion takes priority over a coincident timeout.
                if (done_rise) begin
                    rd_fram_cnt_next = tgt_reg;
                    rd_ok_next       = 1'b1;
                    state_next       = IDLE;
                end else if (tmo_cnt_reg >= TIMEOUT - 32'd1) begin
                    rd_err_next = 1'b1;
                    state_next  = IDLE;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.rd_addr_valid = (state_reg == SETUP) && (dly_cnt_reg >= 4'd4) && (dly_cnt_reg <= 4'd7);
    assign bus.rd_ddr_addr   = addr_reg;
    assign bus.rd_ddr_num    = num_reg;
    assign bus.rd_fram_cnt   = rd_fram_cnt_reg;
    assign bus.rd_repeat     = rd_repeat_reg;
    assign bus.rd_err        = rd_err_reg;

endmodule

// File: tb/tb_rd0_addr_ctrl.sv
// Directed and randomized bench for rd0_addr_ctrl: a frame-level model predicts the slot,
// address, repeat flag and completed-frame index for every request.
module tb_rd0_addr_ctrl;
    localparam int          AW    = 30;
    localparam int          NW    = 28;
    localparam logic [31:0] START = 32'h0000_0000;
    localparam logic [31:0] BLOCK = 32'h0008_0000;
    localparam logic [31:0] NUM   = 32'd3600;
    localparam logic [31:0] TMO   = 32'd100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rd0_addr_ctrl_if #(.ADDR_WIDTH(AW), .RD_NUM_WIDTH(NW)) bus ();

    rd0_addr_ctrl #(
        .START_ADDR(START), .BLOCK_SIZE(BLOCK), .RD_NUM(NUM),
        .ADDR_WIDTH(AW), .RD_NUM_WIDTH(NW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Burst monitor, sampled 1 ns after each rising edge.
    int          n_rises = 0, n_bursts = 0, n_rep = 0, n_err = 0, cur_len = 0, last_len = 0;
    bit          v_prev = 0, rep_since = 0, last_rep = 0;
    logic [31:0] cap_addr = '0, cap_num = '0, last_addr = '0, last_num = '0;

    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            v_prev    = 0;
            rep_since = 0;
            cur_len   = 0;
        end else begin
            if (bus.rd_repeat) begin n_rep++; rep_since = 1; end
            if (bus.rd_err) n_err++;
            if (bus.rd_addr_valid && !v_prev) begin
                n_rises++;
                cur_len  = 0;
                cap_addr = 32'(bus.rd_ddr_addr);
                cap_num  = 32'(bus.rd_ddr_num);
            end
            if (bus.rd_addr_valid) cur_len++;
            if (!bus.rd_addr_valid && v_prev) begin
                n_bursts++;
                last_len  = cur_len;
                last_addr = cap_addr;
                last_num  = cap_num;
                last_rep  = rep_since;
                rep_since = 0;
            end
            v_prev = bus.rd_addr_valid;
        end
    end

    // Frame-level reference state.
    bit         m_ok;
    logic [4:0] m_slot, cur_cnt;
    int         exp_bursts;
    int         k, err0, r0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_vs();
        @(negedge clk) bus.rd_vs = 1'b1;
        repeat (4) @(negedge clk);
        bus.rd_vs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_cnt(input logic [4:0] c);
        @(negedge clk) bus.wr_fram_cnt = c;
        cur_cnt = c;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_req(input bit do_done, input int nvs);
        logic [4:0] t;
        longint     ea;
        bit         er;
        int         w;
        t  = cur_cnt - 5'd1;
        er = m_ok && (t == m_slot);
        ea = ((longint'(START) + longint'(t) * longint'(BLOCK)) * 4) % (64'd1 << AW);
        w  = 0;
        while (n_bursts <= exp_bursts && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk("req_issued", 64'(n_bursts > exp_bursts), 64'd1);
        exp_bursts++;
        chk("addr", 64'(last_addr), 64'(ea));
        chk("num", 64'(last_num), 64'(NUM));
        chk("valid_len", 64'(last_len), 64'd4);
        chk("repeat", 64'(last_rep), 64'(er));
        repeat (nvs) pulse_vs();
        if (do_done) begin
            @(negedge clk) bus.rd_ddr_done = 1'b1;
            repeat (4) @(negedge clk);
            bus.rd_ddr_done = 1'b0;
            m_slot = t;
            m_ok   = 1'b1;
            chk("fram_cnt", 64'(bus.rd_fram_cnt), 64'(m_slot));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_vs = 0; bus.rd_ddr_done = 0; bus.wr_fram_cnt = 0;
        cur_cnt = 0; m_ok = 0; m_slot = 0; exp_bursts = 0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_valid", 64'(bus.rd_addr_valid), 64'd0);
        chk("rst_addr", 64'(bus.rd_ddr_addr), 64'd0);
        chk("rst_num", 64'(bus.rd_ddr_num), 64'd0);
        chk("rst_fram", 64'(bus.rd_fram_cnt), 64'd0);
        chk("rst_repeat", 64'(bus.rd_repeat), 64'd0);
        chk("rst_err", 64'(bus.rd_err), 64'd0);
        rst = 1'b0;

        // Nothing written yet: vsync is dropped, and not remembered once writing starts.
        pulse_vs();
        repeat (100) @(negedge clk);
        chk("no_req_before_write", 64'(n_rises), 64'd0);
        set_cnt(5'd3);
        repeat (20) @(negedge clk);
        chk("dropped_vs_not_pending", 64'(n_rises), 64'd0);

        // Slot 2 at byte address 0x400000.
        pulse_vs();
        expect_req(1, 0);

        // done outside REQ is ignored.
        repeat (5) @(negedge clk);
        bus.rd_ddr_done = 1'b1;
        repeat (4) @(negedge clk);
        bus.rd_ddr_done = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_done_fram", 64'(bus.rd_fram_cnt), 64'(m_slot));
        chk("idle_done_no_req", 64'(n_rises), 64'(exp_bursts));

        // Counter wrapped to 0 -> slot 31; second vsync re-reads it.
        set_cnt(5'd0);
        pulse_vs();
        expect_req(1, 0);
        pulse_vs();
        expect_req(1, 0);

        // Two vsyncs during REQ collapse into one follow-up request.
        set_cnt(5'd7);
        pulse_vs();
        expect_req(1, 2);
        expect_req(1, 0);
        repeat (100) @(negedge clk);
        chk("vs_collapsed", 64'(n_rises), 64'(exp_bursts));

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) != 0) set_cnt(5'($urandom_range(0, 31)));
            repeat (3) @(negedge clk);
            pulse_vs();
            expect_req(1, 0);
        end

        // No done: abort after TIMEOUT cycles in REQ.
        set_cnt(5'd9);
        err0 = n_err;
        pulse_vs();
        expect_req(0, 0);
        k = 0;
        while (k < 150) begin
            @(negedge clk);
            k++;
            if (bus.rd_err) break;
        end
        chk("timeout_cycles", 64'(k), 64'd101);
        @(negedge clk);
        chk("err_pulse_width", 64'(bus.rd_err), 64'd0);
        chk("err_count", 64'(n_err), 64'(err0 + 1));
        chk("timeout_fram", 64'(bus.rd_fram_cnt), 64'(m_slot));

        // Reset in the middle of SETUP.
        repeat (5) @(negedge clk);
        bus.rd_vs = 1'b1;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            k++;
            if (k == 4) bus.rd_vs = 1'b0;
            if (bus.rd_addr_valid) break;
        end
        chk("valid_before_rst", 64'(bus.rd_addr_valid), 64'd1);
        bus.rd_vs = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", 64'(bus.rd_addr_valid), 64'd0);
        chk("rst_mid_fram", 64'(bus.rd_fram_cnt), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ok = 0;
        m_slot = 0;
        r0 = n_rises;
        repeat (100) @(negedge clk);
        chk("pending_discarded", 64'(n_rises), 64'(r0));

        // Same counter after reset: no repeat since nothing has been read since.
        pulse_vs();
        expect_req(1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
